// File: rtl/axis_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_rr_arbiter_if
//  Purpose  : Bundles the N upstream AXI-Stream lanes and the single
//             downstream AXI-Stream lane of the round-robin arbiter.
//  Signals  : s_tdata  [N*DW] lane i at bits [i*DW +: DW]
//             s_tvalid [N], s_tready [N], s_tlast [N]
//             m_tdata  [DW], m_tvalid, m_tready, m_tlast, m_tid [IW]
//  Modports : slave  - arbiter side (consumes s_*, produces m_*)
//             master - environment side (produces s_*, consumes m_*)
//  Revision : 1.0  initial release
// ============================================================================
interface axis_rr_arbiter_if #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );
endinterface
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axis_rr_arbiter
//  Purpose  : Packet-granular round-robin arbiter sharing one registered
//             AXI-Stream output among N sources. A grant is held from the
//             first beat until the tlast beat is accepted; the source of
//             each output beat is reported on m_tid.
//  Ports    : clk     - clock, rising edge
//             rstn    - synchronous active-low reset
//             axis_io - axis_rr_arbiter_if.slave (s_* inputs, m_* output)
//  Revision : 1.0  initial release
// ============================================================================
module axis_rr_arbiter #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  wire                      clk,
    input  wire                      rstn,
    axis_rr_arbiter_if.slave         axis_io
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   last_grant_q;
    logic [DW-1:0]   m_tdata_q;
    logic            m_tvalid_q;
    logic            m_tlast_q;
    logic [IW-1:0]   m_tid_q;

    logic            win_found;
    logic [IW-1:0]   grant_d;
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic [N-1:0]    ready_vec;
    logic            out_free;
    logic            take;

    // Round-robin search: offsets are scanned from the farthest (N) down to
    // the nearest (1) relative to last_grant, so the last hit written is the
    // closest requester above last_grant, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        grant_d   = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (axis_io.s_tvalid[i] && (((int'(last_grant_q) + k) % N) == i)) begin
                    win_found = 1'b1;
                    grant_d   = IW'(i);
                end
            end
        end
    end

    // Output register can accept a beat when empty or draining this cycle.
    assign out_free = !m_tvalid_q || axis_io.m_tready;

    // Lane mux for the granted source and the one-hot ready vector.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        ready_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == IW'(i)) begin
                sel_valid    = axis_io.s_tvalid[i];
                sel_last     = axis_io.s_tlast[i];
                sel_data     = axis_io.s_tdata[i*DW +: DW];
                ready_vec[i] = (state_q == LOCK) && out_free;
            end
        end
    end

    assign take = (state_q == LOCK) && out_free && sel_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(N - 1);
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tid_q      <= '0;
        end else begin
            // Drain the output register; a beat loaded below overrides this.
            if (m_tvalid_q && axis_io.m_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q <= grant_d;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (take) begin
                        m_tdata_q  <= sel_data;
                        m_tlast_q  <= sel_last;
                        m_tid_q    <= grant_q;
                        m_tvalid_q <= 1'b1;
                        if (sel_last) begin
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axis_io.s_tready = ready_vec;
    assign axis_io.m_tdata  = m_tdata_q;
    assign axis_io.m_tvalid = m_tvalid_q;
    assign axis_io.m_tlast  = m_tlast_q;
    assign axis_io.m_tid    = m_tid_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_rr_arbiter
//  Purpose  : Directed self-checking bench for axis_rr_arbiter. Each source
//             is a small packet generator that advances one beat per
//             accepted handshake; outputs are compared against hand-derived
//             cycle tables.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_rr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axis_rr_arbiter_if #(.DW(DW), .N(N), .IW(IW)) bus ();

    axis_rr_arbiter #(.DW(DW), .N(N), .IW(IW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .axis_io (bus)
    );

    // Per-source packet generator state
    logic [DW-1:0] src_data [N][8];
    int            src_len  [N];
    int            src_beat [N];
    bit            src_act  [N];
    bit            src_hold [N];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.s_tvalid[i]         = src_act[i] && !src_hold[i];
            bus.s_tdata[i*DW +: DW] = src_act[i] ? src_data[i][src_beat[i]] : '0;
            bus.s_tlast[i]          = src_act[i] && (src_beat[i] == src_len[i] - 1);
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < N; i++) begin
            src_act[i]  = 1'b0;
            src_hold[i] = 1'b0;
            src_len[i]  = 0;
            src_beat[i] = 0;
        end
        drive();
    endtask

    task automatic load(input int idx, input int len, input logic [DW-1:0] base,
                        input logic [DW-1:0] inc);
        for (int k = 0; k < len; k++) src_data[idx][k] = base + DW'(k) * inc;
        src_len[idx]  = len;
        src_beat[idx] = 0;
        src_act[idx]  = 1'b1;
        drive();
    endtask

    // One clock: capture handshakes mid-cycle, advance sources after the edge.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = bus.s_tvalid & bus.s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                src_beat[i]++;
                if (src_beat[i] == src_len[i]) src_act[i] = 1'b0;
            end
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        src_clear();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b exp 0", bus.m_tvalid); end
        checks++; if (bus.m_tdata !== 8'h00) begin errors++; $display("FAIL reset_m_tdata got %h exp 00", bus.m_tdata); end
        checks++; if (bus.m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast got %b exp 0", bus.m_tlast); end
        checks++; if (bus.m_tid !== 2'd0) begin errors++; $display("FAIL reset_m_tid got %0d exp 0", bus.m_tid); end
        checks++; if (bus.s_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_tready got %b exp 0000", bus.s_tready); end
    endtask

    task automatic test_single_packet();
        logic          ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]    ed [5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        logic          el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]    er [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        do_reset();
        load(2, 3, 8'h11, 8'h11);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (bus.m_tvalid !== ev[k]) begin errors++; $display("FAIL single_valid c%0d got %b exp %b", k, bus.m_tvalid, ev[k]); end
            checks++; if (bus.s_tready !== er[k]) begin errors++; $display("FAIL single_ready c%0d got %b exp %b", k, bus.s_tready, er[k]); end
            if (ev[k]) begin
                checks++; if (bus.m_tdata !== ed[k]) begin errors++; $display("FAIL single_data c%0d got %h exp %h", k, bus.m_tdata, ed[k]); end
                checks++; if (bus.m_tlast !== el[k]) begin errors++; $display("FAIL single_last c%0d got %b exp %b", k, bus.m_tlast, el[k]); end
                checks++; if (bus.m_tid !== 2'd2) begin errors++; $display("FAIL single_tid c%0d got %0d exp 2", k, bus.m_tid); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic       ev [13] = '{0,1,1,0,1,1,0,1,1,0,1,1,0};
        logic [7:0] ed [13] = '{8'h00,8'hA0,8'hA1,8'h00,8'hB0,8'hB1,8'h00,8'hC0,8'hC1,8'h00,8'hD0,8'hD1,8'h00};
        logic       el [13] = '{0,0,1,0,0,1,0,0,1,0,0,1,0};
        logic [1:0] ei [13] = '{0,0,0,0,1,1,0,2,2,0,3,3,0};
        logic [3:0] er [13] = '{4'b0001,4'b0001,4'b0000,4'b0010,4'b0010,4'b0000,
                                4'b0100,4'b0100,4'b0000,4'b1000,4'b1000,4'b0000,4'b0000};
        do_reset();
        for (int i = 0; i < N; i++) load(i, 2, 8'hA0 + 8'(i * 16), 8'h01);
        for (int k = 0; k < 13; k++) begin
            step();
            checks++; if (bus.m_tvalid !== ev[k]) begin errors++; $display("FAIL rr_valid c%0d got %b exp %b", k, bus.m_tvalid, ev[k]); end
            checks++; if (bus.s_tready !== er[k]) begin errors++; $display("FAIL rr_ready c%0d got %b exp %b", k, bus.s_tready, er[k]); end
            if (ev[k]) begin
                checks++; if (bus.m_tdata !== ed[k]) begin errors++; $display("FAIL rr_data c%0d got %h exp %h", k, bus.m_tdata, ed[k]); end
                checks++; if (bus.m_tlast !== el[k]) begin errors++; $display("FAIL rr_last c%0d got %b exp %b", k, bus.m_tlast, el[k]); end
                checks++; if (bus.m_tid !== ei[k]) begin errors++; $display("FAIL rr_tid c%0d got %0d exp %0d", k, bus.m_tid, ei[k]); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load(1, 4, 8'h50, 8'h01);
        step(); step(); step();
        checks++; if (bus.m_tdata !== 8'h51) begin errors++; $display("FAIL bp_pre_data got %h exp 51", bus.m_tdata); end
        bus.m_tready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (bus.m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b exp 1", k, bus.m_tvalid); end
            checks++; if (bus.m_tdata !== 8'h51) begin errors++; $display("FAIL bp_data c%0d got %h exp 51", k, bus.m_tdata); end
            checks++; if (bus.m_tid !== 2'd1) begin errors++; $display("FAIL bp_tid c%0d got %0d exp 1", k, bus.m_tid); end
            checks++; if (bus.m_tlast !== 1'b0) begin errors++; $display("FAIL bp_last c%0d got %b exp 0", k, bus.m_tlast); end
            checks++; if (bus.s_tready !== 4'b0000) begin errors++; $display("FAIL bp_ready c%0d got %b exp 0000", k, bus.s_tready); end
        end
        bus.m_tready = 1'b1;
        #1;
        checks++; if (bus.s_tready !== 4'b0010) begin errors++; $display("FAIL bp_resume_ready got %b exp 0010", bus.s_tready); end
        step();
        checks++; if (bus.m_tdata !== 8'h52 || bus.m_tlast !== 1'b0) begin errors++; $display("FAIL bp_beat2 got %h/%b exp 52/0", bus.m_tdata, bus.m_tlast); end
        step();
        checks++; if (bus.m_tdata !== 8'h53 || bus.m_tlast !== 1'b1) begin errors++; $display("FAIL bp_beat3 got %h/%b exp 53/1", bus.m_tdata, bus.m_tlast); end
        step();
        checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus.m_tvalid); end
    endtask

    task automatic test_bubble_hold();
        do_reset();
        load(3, 3, 8'h70, 8'h01);
        step(); step();
        checks++; if (bus.m_tdata !== 8'h70 || bus.m_tid !== 2'd3) begin errors++; $display("FAIL hold_first got %h/%0d exp 70/3", bus.m_tdata, bus.m_tid); end
        src_hold[3] = 1'b1;
        load(0, 2, 8'h80, 8'h01);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.s_tready !== 4'b1000) begin errors++; $display("FAIL hold_ready c%0d got %b exp 1000", k, bus.s_tready); end
            checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL hold_valid c%0d got %b exp 0", k, bus.m_tvalid); end
        end
        src_hold[3] = 1'b0;
        drive();
        step();
        checks++; if (bus.m_tdata !== 8'h71 || bus.m_tid !== 2'd3) begin errors++; $display("FAIL hold_b2 got %h/%0d exp 71/3", bus.m_tdata, bus.m_tid); end
        step();
        checks++; if (bus.m_tdata !== 8'h72 || bus.m_tlast !== 1'b1) begin errors++; $display("FAIL hold_b3 got %h/%b exp 72/1", bus.m_tdata, bus.m_tlast); end
        step();
        checks++; if (bus.s_tready !== 4'b0001 || bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL hold_switch got %b/%b exp 0001/0", bus.s_tready, bus.m_tvalid); end
        step();
        checks++; if (bus.m_tdata !== 8'h80 || bus.m_tid !== 2'd0) begin errors++; $display("FAIL hold_in0 got %h/%0d exp 80/0", bus.m_tdata, bus.m_tid); end
    endtask

    task automatic test_wraparound();
        do_reset();
        load(3, 1, 8'h90, 8'h00);
        step(); step();
        checks++; if (bus.m_tdata !== 8'h90 || bus.m_tlast !== 1'b1) begin errors++; $display("FAIL wrap_pre got %h/%b exp 90/1", bus.m_tdata, bus.m_tlast); end
        load(0, 1, 8'hA5, 8'h00);
        load(3, 1, 8'h95, 8'h00);
        step();
        checks++; if (bus.s_tready !== 4'b0001) begin errors++; $display("FAIL wrap_grant0 got %b exp 0001", bus.s_tready); end
        step();
        checks++; if (bus.m_tdata !== 8'hA5 || bus.m_tid !== 2'd0) begin errors++; $display("FAIL wrap_beat0 got %h/%0d exp A5/0", bus.m_tdata, bus.m_tid); end
        load(0, 1, 8'hA6, 8'h00);
        step();
        checks++; if (bus.s_tready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3 got %b exp 1000", bus.s_tready); end
        step();
        checks++; if (bus.m_tdata !== 8'h95 || bus.m_tid !== 2'd3) begin errors++; $display("FAIL wrap_beat3 got %h/%0d exp 95/3", bus.m_tdata, bus.m_tid); end
        step(); step();
        checks++; if (bus.m_tdata !== 8'hA6 || bus.m_tid !== 2'd0) begin errors++; $display("FAIL wrap_again0 got %h/%0d exp A6/0", bus.m_tdata, bus.m_tid); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        load(1, 1, 8'h40, 8'h00);
        step(); step();
        load(2, 4, 8'h30, 8'h01);
        step(); step();
        checks++; if (bus.m_tdata !== 8'h30 || bus.m_tid !== 2'd2) begin errors++; $display("FAIL mrst_pre got %h/%0d exp 30/2", bus.m_tdata, bus.m_tid); end
        rstn = 1'b0;
        step();
        checks++; if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== 8'h00 || bus.m_tlast !== 1'b0 || bus.m_tid !== 2'd0)
            begin errors++; $display("FAIL mrst_out got v%b d%h l%b id%0d exp all 0", bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.m_tid); end
        checks++; if (bus.s_tready !== 4'b0000) begin errors++; $display("FAIL mrst_ready got %b exp 0000", bus.s_tready); end
        rstn = 1'b1;
        src_clear();
        load(0, 1, 8'hE0, 8'h00);
        load(2, 1, 8'hE2, 8'h00);
        step();
        checks++; if (bus.s_tready !== 4'b0001) begin errors++; $display("FAIL mrst_grant got %b exp 0001", bus.s_tready); end
        step();
        checks++; if (bus.m_tdata !== 8'hE0 || bus.m_tid !== 2'd0 || bus.m_tvalid !== 1'b1) begin errors++; $display("FAIL mrst_beat got %h/%0d exp E0/0", bus.m_tdata, bus.m_tid); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rstn         = 1'b0;
        bus.m_tready = 1'b1;
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_bubble_hold();
        test_wraparound();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-input AXI-Stream arbiter: shares a single registered AXI-Stream output among N upstream stream sources.
- Arbitration is round-robin at packet granularity. The grant is held from the first beat until the beat carrying tlast is accepted, so packets never interleave.
- Sits in front of the single-lane stream register stage. Source index of the current beat is reported on m_tid.

Parameters:
- DW, 8, data width per beat.
- N, 4, number of requesting inputs (2..16).
- IW, 2, width of m_tid; must satisfy 2^IW >= N.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- s_tdata  input  N*DW  packed input data; input i occupies bits [i*DW +: DW].
- s_tvalid  input  N  per-input valid.
- s_tready  output  N  per-input ready; at most one bit set in any cycle.
- s_tlast  input  N  per-input end-of-packet.
- m_tdata  output  DW  registered output data.
- m_tvalid  output  1  registered output valid.
- m_tready  input  1  downstream ready.
- m_tlast  output  1  registered end-of-packet.
- m_tid  output  IW  index of the input that sourced the current m_tdata beat.

Behaviour:
- Reset (rstn=0 at clk edge) sets:
  - m_tdata=0, m_tvalid=0, m_tlast=0, m_tid=0.
  - s_tready=0; state=IDLE; grant=0.
  - last_grant=N-1, so input 0 has first priority after reset.
- Reset mid-packet discards the held beat and the lock. No partial-packet completion.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - s_tready=0.
  - If any s_tvalid is set, pick the first set bit searching upward from last_grant+1, modulo N.
  - Next cycle: grant=winner, state=LOCK.
  - If no s_tvalid is set, stay in IDLE.
- LOCK:
  - out_free = !m_tvalid || m_tready.
  - s_tready[grant] = out_free; all other s_tready bits are 0.
  - A beat transfers when s_tvalid[grant] && s_tready[grant]. On that edge:
    - m_tdata <= s_tdata[grant]
    - m_tlast <= s_tlast[grant]
    - m_tid <= grant
    - m_tvalid <= 1
  - If that beat has s_tlast=1: last_grant <= grant and state <= IDLE.
- Output register:
  - If m_tvalid && m_tready and no new beat loads, m_tvalid <= 0.
  - If m_tvalid && !m_tready, m_tdata, m_tlast and m_tid hold stable and m_tvalid stays 1.
- Latency:
  - First beat of a packet: 2 cycles from s_tvalid rising in IDLE to m_tvalid (1 cycle arbitrate, 1 cycle register).
  - Following beats: 1 cycle each.
  - Sustained throughput within a packet is 1 beat/clk while m_tready=1.
- Inter-packet gap: at least 1 idle cycle on the input side per packet (the IDLE arbitration cycle).
- A granted input that drops s_tvalid mid-packet keeps the grant. Bubbles are allowed; no re-arbitration until tlast.
- s_tvalid changing on non-granted inputs during LOCK has no effect.
- Fairness: with all N inputs continuously requesting, grants rotate 0,1,..,N-1,0.
- Single requester: re-granted every packet, with the 1-cycle IDLE gap between packets.
- Simultaneous events: tlast acceptance and a new request in the same cycle resolve in the next IDLE cycle, using the updated last_grant.
- A single-beat packet (tlast on the first beat) is legal. It occupies 1 LOCK cycle when out_free.
- The input-to-output path is never combinational. All m_* outputs come from flops.
- s_tready is combinational from state, grant, m_tvalid and m_tready.

Test Plan:
1. Reset, then s_tvalid=4'b0100 with a 3-beat packet 0x11,0x22,0x33 (tlast on 0x33), m_tready=1 → m_tvalid rises 2 cycles later; m_tdata=0x11,0x22,0x33 on consecutive cycles; m_tid=2; m_tlast=1 only with 0x33.
2. All four inputs each request a 2-beat packet at once, m_tready=1 → packets emerge in order m_tid=0,1,2,3; no beat interleaving; each packet followed by a 1-cycle input gap.
3. Input 1 is mid-packet, then m_tready is held 0 for 5 cycles → m_tdata/m_tid/m_tlast stable and m_tvalid=1 throughout; s_tready=0 on all inputs; resumes with no lost or duplicated beat.
4. Input 3 drops s_tvalid for 3 cycles mid-packet while input 0 requests → grant stays on 3; input 0 is served only after input 3's tlast beat is accepted.
5. After a packet from input 3, inputs 0 and 3 both request → grant goes to 0 (wrap-around from last_grant=3). The next contest between 0 and 3 goes to 3.
6. Assert rstn=0 for 1 cycle during beat 2 of a 4-beat packet → next cycle all outputs are 0 and state is IDLE. Re-requesting input 0 is granted first.
